// File: rtl/wb_regfile_stage_pkg.sv
// riscv_pkg: shared RV32I datapath widths and load funct3 encodings.
package riscv_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/wb_regfile_stage_if.sv
// wb_regfile_stage_if: EX/WB register fields in, ID read ports and committed-write export out.
interface wb_regfile_stage_if
   import riscv_pkg::*;
#(
   parameter int CNT_W = 32
);
   logic                  regwrite_in;
   logic                  memtoreg_in;
   logic [XLEN-1:0]       alu_result_in;
   logic [XLEN-1:0]       mem_data_in;
   logic [2:0]            load_fmt_in;
   logic [REG_ADDR_W-1:0] rd_in;
   logic [REG_ADDR_W-1:0] rs1_addr;
   logic [REG_ADDR_W-1:0] rs2_addr;
   logic [XLEN-1:0]       rs1_data;
   logic [XLEN-1:0]       rs2_data;
   logic                  wb_we_out;
   logic [REG_ADDR_W-1:0] wb_rd_out;
   logic [XLEN-1:0]       wb_data_out;
   logic [CNT_W-1:0]      wb_count;
   modport master (
      output regwrite_in, memtoreg_in, alu_result_in, mem_data_in, load_fmt_in, rd_in,
             rs1_addr, rs2_addr,
      input  rs1_data, rs2_data, wb_we_out, wb_rd_out, wb_data_out, wb_count
   );
   modport slave (
      input  regwrite_in, memtoreg_in, alu_result_in, mem_data_in, load_fmt_in, rd_in,
             rs1_addr, rs2_addr,
      output rs1_data, rs2_data, wb_we_out, wb_rd_out, wb_data_out, wb_count
   );
endinterface

// File: rtl/wb_regfile_stage_align.sv
// wb_load_align: picks the byte/half lane of a loaded word and sign- or zero-extends it.
module wb_load_align
   import riscv_pkg::*;
(
   input  logic [XLEN-1:0] mem_data_i,
   input  logic [1:0]      addr_lo_i,
   input  logic [2:0]      load_fmt_i,
   output logic [XLEN-1:0] data_o
);
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   // Halfword lane uses only addr bit 1; bit 0 of a misaligned half is ignored.
   always_comb begin
      byte_v = mem_data_i[{addr_lo_i, 3'b000} +: 8];
      half_v = addr_lo_i[1] ? mem_data_i[31:16] : mem_data_i[15:0];
      data_o = load_fmt_i == F3_LB  ? {{(XLEN-8){byte_v[7]}}, byte_v} :
               load_fmt_i == F3_LH  ? {{(XLEN-16){half_v[15]}}, half_v} :
               load_fmt_i == F3_LBU ? {{(XLEN-8){1'b0}}, byte_v} :
               load_fmt_i == F3_LHU ? {{(XLEN-16){1'b0}}, half_v} :
                                      mem_data_i;
   end
endmodule

// File: rtl/wb_regfile_stage.sv
// wb_regfile_stage: writeback select/align, 32-entry register file with two read ports, commit counter.
// Define WB_REGFILE_BYPASS_EN to make a same-cycle write visible on the read ports (write-through).
module wb_regfile_stage
   import riscv_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int CNT_W = 32
)(
   input  logic clock,
   input  logic reset,
   wb_regfile_stage_if.slave bus
);
   logic [XLEN-1:0]  load_val;
   logic [XLEN-1:0]  wb_data;
   logic             we;
   logic             byp1;
   logic             byp2;
   logic [XLEN-1:0]  regs_q [NREGS];
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   wb_load_align u_align (
      .mem_data_i (bus.mem_data_in),
      .addr_lo_i  (bus.alu_result_in[1:0]),
      .load_fmt_i (bus.load_fmt_in),
      .data_o     (load_val)
   );

   assign wb_data = bus.memtoreg_in ? load_val : bus.alu_result_in;
   assign we      = bus.regwrite_in && bus.rd_in != '0;
   assign cnt_d   = cnt_q + 1'b1;

`ifdef WB_REGFILE_BYPASS_EN
   assign byp1 = we && bus.rs1_addr == bus.rd_in;
   assign byp2 = we && bus.rs2_addr == bus.rd_in;
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif

   // x0 is never written, but reads are still forced to zero so bypass cannot leak into it.
   assign bus.rs1_data    = bus.rs1_addr == '0 ? '0 : byp1 ? wb_data : regs_q[bus.rs1_addr];
   assign bus.rs2_data    = bus.rs2_addr == '0 ? '0 : byp2 ? wb_data : regs_q[bus.rs2_addr];
   assign bus.wb_we_out   = we;
   assign bus.wb_rd_out   = bus.rd_in;
   assign bus.wb_data_out = wb_data;
   assign bus.wb_count    = cnt_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
         cnt_q <= '0;
      end else if (we) begin
         regs_q[bus.rd_in] <= wb_data;
         cnt_q             <= cnt_d;
      end
   end
endmodule
